// File: rtl/m_imem_loader.sv
// rtl/m_imem_loader.sv - length-prefixed byte stream loader for the 2048x32 instruction memory (optional trailing checksum: IMEM_LOADER_CSUM_EN)
module m_imem_loader #(
    parameter int ADDR_W = 11,
    parameter int DEPTH  = 2048
) (
    input  logic              w_clk,
    input  logic              w_rst,
    input  logic              w_rx_valid,
    input  logic [7:0]        w_rx_data,
    output logic              w_rx_ready,
    output logic              w_mem_we,
    output logic [ADDR_W-1:0] w_mem_addr,
    output logic [31:0]       w_mem_din,
    output logic              w_run,
    output logic              w_busy,
    output logic              w_err
);

    typedef enum logic [2:0] {
        S_CNT_HI,
        S_CNT_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERR,
        S_CSUM
    } state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH);

    state_t            state;
    logic [7:0]        cnt_hi_q;
    logic [ADDR_W:0]   n_q;
    logic [ADDR_W:0]   word_idx;
    logic [1:0]        byte_cnt;
    logic [31:0]       asm_q;
    logic              xfer;
    logic [15:0]       n_full;
`ifdef IMEM_LOADER_CSUM_EN
    logic [7:0]        csum_q;
`endif

    assign xfer   = w_rx_valid & w_rx_ready;
    assign n_full = {cnt_hi_q, w_rx_data};

    // Ready depends only on state; forced low while reset is asserted so no byte is lost in the reset cycle
    always_comb begin
        w_rx_ready = 1'b0;
        if (!w_rst) begin
            case (state)
                S_CNT_HI, S_CNT_LO, S_DATA, S_ERR, S_CSUM: w_rx_ready = 1'b1;
                default:                                   w_rx_ready = 1'b0;
            endcase
        end
    end

    // Loader FSM: count header, byte packing, one-cycle write strobe, terminal DONE/ERR
    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state      <= S_CNT_HI;
            cnt_hi_q   <= '0;
            n_q        <= '0;
            word_idx   <= '0;
            byte_cnt   <= '0;
            asm_q      <= '0;
            w_mem_we   <= 1'b0;
            w_mem_addr <= '0;
            w_mem_din  <= '0;
            w_run      <= 1'b0;
            w_busy     <= 1'b0;
            w_err      <= 1'b0;
`ifdef IMEM_LOADER_CSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            w_mem_we <= 1'b0;
            case (state)
                S_CNT_HI: begin
                    if (xfer) begin
                        cnt_hi_q <= w_rx_data;
                        w_busy   <= 1'b1;
                        state    <= S_CNT_LO;
                    end
                end
                S_CNT_LO: begin
                    if (xfer) begin
                        if (n_full == 16'd0) begin
`ifdef IMEM_LOADER_CSUM_EN
                            state  <= S_CSUM;
`else
                            state  <= S_DONE;
                            w_run  <= 1'b1;
                            w_busy <= 1'b0;
`endif
                        end else if ({1'b0, n_full} > DEPTH_L) begin
                            state  <= S_ERR;
                            w_err  <= 1'b1;
                            w_busy <= 1'b0;
                        end else begin
                            n_q   <= n_full[ADDR_W:0];
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        asm_q    <= {asm_q[23:0], w_rx_data};
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CSUM_EN
                        csum_q   <= csum_q ^ w_rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            w_mem_we   <= 1'b1;
                            w_mem_addr <= word_idx[ADDR_W-1:0];
                            w_mem_din  <= {asm_q[23:0], w_rx_data};
                            state      <= S_WRITE;
                        end
                    end
                end
                S_WRITE: begin
                    word_idx <= word_idx + 1'b1;
                    if (word_idx + 1'b1 == n_q) begin
`ifdef IMEM_LOADER_CSUM_EN
                        state  <= S_CSUM;
`else
                        state  <= S_DONE;
                        w_run  <= 1'b1;
                        w_busy <= 1'b0;
`endif
                    end else begin
                        state <= S_DATA;
                    end
                end
`ifdef IMEM_LOADER_CSUM_EN
                S_CSUM: begin
                    if (xfer) begin
                        w_busy <= 1'b0;
                        if (w_rx_data == csum_q) begin
                            state <= S_DONE;
                            w_run <= 1'b1;
                        end else begin
                            state <= S_ERR;
                            w_err <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= state;
            endcase
        end
    end

endmodule
